// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/line widths plus the L2 arbiter state and port encodings.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_SERVE   = 2'b01,
        ARB_RESPOND = 2'b10
    } l2_arb_state_t;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } l2_arb_port_t;

    localparam lc3b_word LINE_ADDR_MASK = 16'hFFF0;

    // Round-robin pick: on a tie the port that did not win last time gets the grant.
    function automatic l2_arb_port_t rr_pick(input logic i_req, input logic d_req,
                                             input l2_arb_port_t last_grant);
        l2_arb_port_t pick;
        if (i_req && d_req) begin
            pick = (last_grant == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
        end else if (d_req) begin
            pick = ARB_PORT_D;
        end else begin
            pick = ARB_PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: o_f = i_sel ? i_b : i_a.
module mux2 #(
    parameter int WIDTH = 16
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_f
);

    assign o_f = i_sel ? i_b : i_a;

endmodule

// File: rtl/register.sv
// Load-enabled register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Storage element: cleared by reset, captures i_d when loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter between the L1 I-cache and D-cache toward the L2; one
// outstanding line transaction at a time, with all outputs decoded from registers.
module l2_arbiter
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_read,
    input  lc3b_word i_address,
    output lc3b_line i_rdata,
    output logic     i_resp,
    input  logic     d_read,
    input  logic     d_write,
    input  lc3b_word d_address,
    input  lc3b_line d_wdata,
    output lc3b_line d_rdata,
    output logic     d_resp,
    output logic     cache_read,
    output logic     cache_write,
    output lc3b_word cache_address,
    output lc3b_line cache_wdata,
    input  lc3b_line cache_rdata,
    input  logic     cache_resp
);

    l2_arb_state_t r_state;
    l2_arb_state_t w_next_state;
    l2_arb_port_t  r_owner;
    l2_arb_port_t  r_last_grant;
    l2_arb_port_t  w_grant;
    logic          r_is_write;
    logic          w_req_write;
    logic          w_i_req;
    logic          w_d_req;
    logic          w_sel_d;
    logic          w_load_req;
    logic          w_load_resp;
    lc3b_word      w_sel_addr;
    lc3b_word      r_addr;
    lc3b_line      w_sel_wdata;
    lc3b_line      r_wdata;
    lc3b_line      r_rdata;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_sel_d = (w_grant == ARB_PORT_D);

    // Grant selection; a D-side read+write conflict resolves to the write.
    always_comb begin
        w_grant     = rr_pick(w_i_req, w_d_req, r_last_grant);
        w_req_write = 1'b0;
        if (w_grant == ARB_PORT_D) begin
            w_req_write = d_write;
        end else begin
            w_req_write = 1'b0;
        end
    end

    mux2 #(.WIDTH(16)) u_addr_mux (
        .i_sel (w_sel_d),
        .i_a   (i_address),
        .i_b   (d_address),
        .o_f   (w_sel_addr)
    );

    mux2 #(.WIDTH(128)) u_wdata_mux (
        .i_sel (w_sel_d),
        .i_a   (128'h0),
        .i_b   (d_wdata),
        .o_f   (w_sel_wdata)
    );

    register #(.WIDTH(16)) u_addr_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load_req),
        .i_d    (w_sel_addr & LINE_ADDR_MASK),
        .o_q    (r_addr)
    );

    register #(.WIDTH(128)) u_wdata_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load_req),
        .i_d    (w_sel_wdata),
        .o_q    (r_wdata)
    );

    register #(.WIDTH(128)) u_rdata_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load_resp),
        .i_d    (cache_rdata),
        .o_q    (r_rdata)
    );

    // FSM state, transaction owner/op and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_PORT_I;
            r_last_grant <= ARB_PORT_I;
            r_is_write   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load_req) begin
                r_owner    <= w_grant;
                r_is_write <= w_req_write;
            end
            if (r_state == ARB_RESPOND) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // Next-state and register-load decode; cache_resp only matters in SERVE.
    always_comb begin
        w_next_state = r_state;
        w_load_req   = 1'b0;
        w_load_resp  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_load_req   = 1'b1;
                    w_next_state = ARB_SERVE;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end
            ARB_SERVE: begin
                if (cache_resp) begin
                    w_load_resp  = 1'b1;
                    w_next_state = ARB_RESPOND;
                end else begin
                    w_next_state = ARB_SERVE;
                end
            end
            ARB_RESPOND: w_next_state = ARB_IDLE;
            default:     w_next_state = ARB_IDLE;
        endcase
    end

    assign cache_read    = (r_state == ARB_SERVE) && !r_is_write;
    assign cache_write   = (r_state == ARB_SERVE) &&  r_is_write;
    assign cache_address = r_addr;
    assign cache_wdata   = r_wdata;
    assign i_resp        = (r_state == ARB_RESPOND) && (r_owner == ARB_PORT_I);
    assign d_resp        = (r_state == ARB_RESPOND) && (r_owner == ARB_PORT_D);
    assign i_rdata       = r_rdata;
    assign d_rdata       = r_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter with a hand-driven L2 responder.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         cache_read;
    logic         cache_write;
    logic [15:0]  cache_address;
    logic [127:0] cache_wdata;
    logic [127:0] cache_rdata;
    logic         cache_resp;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    l2_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_rdata       (i_rdata),
        .i_resp        (i_resp),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_resp        (d_resp),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_address (cache_address),
        .cache_wdata   (cache_wdata),
        .cache_rdata   (cache_rdata),
        .cache_resp    (cache_resp)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for the L2 strobe, checks it for 'delay' SERVE cycles, answers, then checks the resp pulse.
    task automatic serve(input string tag, input logic exp_d, input logic exp_wr,
                         input logic [15:0] exp_addr, input logic [127:0] exp_wdata,
                         input int delay, input logic [127:0] rd, input logic perturb);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(cache_read || cache_write) && lat < 10);
        check_eq({tag, "_latency"}, 128'(lat), 128'd1);
        for (int k = 0; k < delay; k++) begin
            check_eq({tag, "_cache_read"},  cache_read,    !exp_wr);
            check_eq({tag, "_cache_write"}, cache_write,   exp_wr);
            check_eq({tag, "_cache_addr"},  cache_address, exp_addr);
            if (exp_wr) check_eq({tag, "_cache_wdata"}, cache_wdata, exp_wdata);
            check_eq({tag, "_early_resp"}, {i_resp, d_resp}, 2'b00);
            if (perturb && k == 0) begin
                i_address = ~i_address;
                d_address = ~d_address;
            end
            if (k == delay - 1) begin
                cache_resp  = 1'b1;
                cache_rdata = rd;
            end
            tick();
        end
        cache_resp  = 1'b0;
        cache_rdata = ~rd;
        check_eq({tag, "_i_resp"}, i_resp, !exp_d);
        check_eq({tag, "_d_resp"}, d_resp, exp_d);
        check_eq({tag, "_strobe_off"}, {cache_read, cache_write}, 2'b00);
        if (!exp_wr) check_eq({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, rd);
        if (exp_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        tick();
        check_eq({tag, "_pulse_end"}, {i_resp, d_resp, cache_read, cache_write}, 4'b0000);
    endtask

    initial begin
        reset = 1'b1; i_read = 1'b0; i_address = 16'h0; d_read = 1'b0; d_write = 1'b0;
        d_address = 16'h0; d_wdata = 128'h0; cache_rdata = 128'h0; cache_resp = 1'b0;
        tick();
        check_eq("reset_strobes", {cache_read, cache_write, i_resp, d_resp}, 4'b0000);
        check_eq("reset_addr",    cache_address, 16'h0000);
        check_eq("reset_rdata",   {i_rdata, d_rdata}, 256'h0);
        reset = 1'b0;
        tick();
        check_eq("idle_after_reset", {cache_read, cache_write, i_resp, d_resp}, 4'b0000);

        // Tie out of reset: D first, then I.
        i_read = 1'b1; i_address = 16'h1111; d_read = 1'b1; d_address = 16'h2229;
        serve("tie1_d", 1'b1, 1'b0, 16'h2220, 128'h0, 1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0);
        serve("tie1_i", 1'b0, 1'b0, 16'h1110, 128'h0, 1, 128'hCAFE_0000_1111_2222_3333_4444_5555_6666, 1'b0);

        d_write = 1'b1; d_address = 16'h4A70;
        d_wdata = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
        serve("dwb", 1'b1, 1'b1, 16'h4A70, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 3, 128'h0, 1'b0);

        // Tie after a D grant: I first, then D.
        i_read = 1'b1; i_address = 16'h0F0F; d_read = 1'b1; d_address = 16'hBEEF;
        serve("tie2_i", 1'b0, 1'b0, 16'h0F00, 128'h0, 1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b0);
        serve("tie2_d", 1'b1, 1'b0, 16'hBEE0, 128'h0, 2, 128'h5A5A_5A5A_0000_FFFF_1357_9BDF_2468_ACE0, 1'b0);

        i_read = 1'b1; i_address = 16'h1238;
        serve("iread", 1'b0, 1'b0, 16'h1230, 128'h0, 2, {16{8'hA5}}, 1'b0);

        d_read = 1'b1; d_write = 1'b1; d_address = 16'h7777; d_wdata = {8{16'h5555}};
        serve("dconf", 1'b1, 1'b1, 16'h7770, {8{16'h5555}}, 1, 128'h0, 1'b0);

        i_read = 1'b1; i_address = 16'h2224;
        serve("chg", 1'b0, 1'b0, 16'h2220, 128'h0, 3, {4{32'h600D_F00D}}, 1'b1);

        // Asynchronous reset in the middle of SERVE drops the transaction.
        i_read = 1'b1; i_address = 16'h3330;
        tick();
        check_eq("pre_reset_read", cache_read, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_eq("midreset_strobes", {cache_read, cache_write, i_resp, d_resp}, 4'b0000);
        check_eq("midreset_addr",    cache_address, 16'h0000);
        check_eq("midreset_rdata",   {i_rdata, d_rdata}, 256'h0);
        tick();
        reset = 1'b0; i_read = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cache_resp  = (c == 1);
            cache_rdata = {4{32'hBAD0_BAD0}};
            tick();
            check_eq("post_reset_idle", {cache_read, cache_write, i_resp, d_resp}, 4'b0000);
            check_eq("stray_resp_rdata", i_rdata, 128'h0);
        end
        cache_resp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1);
    end

endmodule
